// File: rtl/dmem_if.sv
// Mem-stage load/store bus between the pipeline (master) and the data memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    input  stall, resp_valid, resp_rdata, misalign_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    output stall, resp_valid, resp_rdata, misalign_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, pipeline held with stall for
// LATENCY wait cycles, sized store or sized/extended load on the edge entering RESP.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned accesses are flagged
// and suppressed; when undefined, half/word accesses are forced aligned).
module dmem_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LATENCY = 2
) (
  input  logic   clk,
  input  logic   rstn,
  dmem_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               misalign_q, misalign_d;

  logic [31:0]        mem [DEPTH];

  logic [ADDR_W-1:0]  idx_c;
  logic [31:0]        rword_c;
  logic [31:0]        rbyte_sh_c;
  logic [31:0]        rhalf_sh_c;
  logic [31:0]        load_c;
  logic [3:0]         be_c;
  logic [31:0]        wlanes_c;
  logic               misalign_c;
  logic               access_c;
  logic               wr_en_c;

  assign idx_c   = bus.req_addr[ADDR_W+1:2];
  assign rword_c = mem[idx_c];

  // Upper address bits are ignored so the memory wraps.
  if (ADDR_W < 30) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];
  end

  // Misalignment detection (only meaningful with the check enabled).
`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign_c = 1'b0;
    case (bus.req_size)
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = bus.req_addr[0];
      default: misalign_c = (bus.req_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Access happens on the edge that enters RESP; reset suppresses it.
  assign access_c = rstn &&
                    (((state_q == S_IDLE) && bus.req_valid && (LATENCY == 0)) ||
                     ((state_q == S_BUSY) && (cnt_q == '0)));
  assign wr_en_c  = access_c && bus.req_we && !misalign_c;

  // Byte enables and replicated store lanes; half/word ignore the low address bits.
  always_comb begin
    be_c     = 4'b1111;
    wlanes_c = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be_c     = 4'b0001 << bus.req_addr[1:0];
        wlanes_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_c     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes_c = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of the load result.
  always_comb begin
    rbyte_sh_c = rword_c >> {bus.req_addr[1:0], 3'b000};
    rhalf_sh_c = rword_c >> {bus.req_addr[1], 4'b0000};
    case (bus.req_size)
      2'b00:   load_c = {{24{bus.req_sign & rbyte_sh_c[7]}}, rbyte_sh_c[7:0]};
      2'b01:   load_c = {{16{bus.req_sign & rhalf_sh_c[15]}}, rhalf_sh_c[15:0]};
      default: load_c = rword_c;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    misalign_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (access_c) begin
      resp_valid_d = 1'b1;
      misalign_d   = misalign_c;
      resp_rdata_d = (bus.req_we || misalign_c) ? 32'h0 : load_c;
    end
  end

  // FSM and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      misalign_q   <= misalign_d;
    end
  end

  // Byte-enabled memory write; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wlanes_c[8*i +: 8];
      end
    end
  end

  // Global pipeline stall is combinational and forced low during reset.
  assign bus.stall        = rstn && (((state_q == S_IDLE) && bus.req_valid) || (state_q == S_BUSY));
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage RISC-V pipeline. It is the target end of the Mem-stage load/store interface: it accepts one request at a time from the memory-access stage and holds the pipeline with `stall` for a configurable access latency. It then performs the sized store, or returns a sized and sign- or zero-extended load word. Its `stall` output drives the pipeline's global stall.

## Interface
- `ADDR_W`, default 14: word-address bits, giving a memory of 2**ADDR_W 32-bit words.
- `LATENCY`, default 2: extra wait cycles per access, legal range 0..15.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present. The requester holds every `req_*` input stable while `stall`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `req_sign` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `stall` out 1: hold the pipeline.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result. Valid only while `resp_valid`=1; 0 for stores.
- `misalign_err` out 1: pulses together with `resp_valid` when the access is misaligned.

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE
  - `req_valid`=1 with LATENCY>0: go to BUSY and load `cnt`=LATENCY-1.
  - `req_valid`=1 with LATENCY=0: go directly to RESP.
- BUSY
  - `cnt`>0: decrement `cnt`.
  - `cnt`=0: go to RESP.
- Access edge: the clock edge that enters RESP.
  - Memory is indexed by `req_addr[ADDR_W+1:2]`. Higher address bits are ignored, so addresses wrap.
- Store on the access edge, with byte enables:
  - Byte: lane `req_addr[1:0]`, data `req_wdata[7:0]`.
  - Half: lanes {`req_addr[1]`,1} and {`req_addr[1]`,0}, data `req_wdata[15:0]`.
  - Word: all four lanes.
  - Unwritten lanes are preserved.
- Load on the access edge: select the addressed byte or half, extend it per `req_sign`, and register the result into `resp_rdata`.
- RESP
  - `resp_valid`=1 and `stall`=0, so the pipeline advances on this edge.
  - The request still presented in this cycle is the completed one and is ignored.
  - Next state is always IDLE.
- `stall` is combinational: (IDLE and `req_valid`) or BUSY. It is 0 in RESP and 0 while `rstn`=0.
- A new request can therefore be accepted at the earliest in the cycle after RESP.

## Timing
- Request first seen in cycle 0 (IDLE):
  - `stall`=1 in cycles 0..LATENCY, i.e. LATENCY+1 cycles.
  - `resp_valid`=1 in cycle LATENCY+1.
- Total occupancy is LATENCY+2 cycles per access.
- Load-to-use data is available from the `resp_rdata` register in the RESP cycle. There is no combinational path from memory to the output.
- Reset values: state IDLE, `cnt`=0, `resp_valid`=0, `resp_rdata`=0, `misalign_err`=0, `stall`=0.
- Memory contents are not reset.
- Reset mid-operation (asserting `rstn` in BUSY) aborts the access. No write occurs, no response is generated, and the FSM returns to IDLE immediately (asynchronous).
- If `req_valid` drops during BUSY, this is a protocol violation; the access still completes on the latched-in-place inputs.

## Configuration
- Macro: `DMEM_MISALIGN_CHECK_EN`.
- Defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - A misaligned store is suppressed (memory unchanged).
  - A misaligned load returns `resp_rdata`=0.
  - `misalign_err`=1 in the RESP cycle.
  - Timing is unchanged.
- Undefined:
  - `misalign_err` is tied 0.
  - Half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`. The access is forced aligned.

## Test plan
- Word round trip, LATENCY=2: store 0xDEADBEEF to 0x100, then load word from 0x100.
  - `stall` high for 3 cycles per access.
  - `resp_valid` in cycle 3.
  - `resp_rdata`=0xDEADBEEF.
- Byte store: store byte 0x80 to 0x103, then:
  - Signed byte load from 0x103 → 0xFFFFFF80.
  - Unsigned byte load from 0x103 → 0x00000080.
  - Word load from 0x100 → 0x80ADBEEF.
- Half loads from 0x102 after the byte store:
  - Signed → 0xFFFF80AD.
  - Unsigned → 0x000080AD.
- Misalignment, with the macro defined:
  - Word store of 0x11111111 to 0x101: `misalign_err`=1 with `resp_valid`; a following word load from 0x100 still returns 0x80ADBEEF.
  - Half load from 0x103: `resp_rdata`=0, `misalign_err`=1.
- Reset mid-BUSY: store 0x12345678 to 0x200 (previously 0), pulse `rstn` low in cycle 1.
  - Outputs reset to 0 immediately.
  - A subsequent word load from 0x200 returns 0x00000000.
- Back-to-back, and the LATENCY=0 build:
  - Two consecutive loads: the second load's `stall` starts in the cycle after the first load's RESP cycle.
  - LATENCY=0: `stall` is high for exactly 1 cycle and `resp_valid` arrives in cycle 1.
